keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad by driving rows low one at a time and sampling the columns. It debounces the result and emits a one-cycle strobe for each accepted keypress, using the {row_val, col_val} active-low key coordinate format. It sits between the board keypad pins and keypad_unit, which consumes key_coord.

---
 rtl/keypad_scanner.sv | 231 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, samples the columns
// once per slot, classifies each full frame and debounces presses and releases.
module keypad_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [7:0] key_coord,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_released
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  // True when exactly one column line is pulled low.
  function automatic logic is_single_low(input logic [3:0] c);
    logic r;
    case (c)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  logic [3:0]    sync1_q, sync2_q;
  logic [SW-1:0] slot_q, slot_d;
  logic [3:0]    row_q, row_d;
  logic          hit_q, hit_d;
  logic          multi_q, multi_d;
  logic [7:0]    code_q, code_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    cand_q, cand_d;
  logic [7:0]    coord_q, coord_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic          released_q, released_d;

  logic          slot_last_s;
  logic          frame_end_s;
  logic          slot_hit_s;
  logic          acc_hit_s;
  logic          acc_multi_s;
  logic          frame_single_s;
  logic [7:0]    frame_code_s;
  logic [CW-1:0] cnt_inc_s;
  logic          match_cand_s;
  logic          match_key_s;

  // Two-stage synchronizer for the asynchronous column lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= col_in;
      sync2_q <= sync1_q;
    end
  end

  assign slot_last_s = (slot_q == SLOT_LAST);
  assign frame_end_s = slot_last_s && (row_q == 4'b0111);
  assign slot_hit_s  = (sync2_q != 4'hF);

  // Frame classification includes the slot being sampled this cycle.
  assign acc_hit_s      = hit_q | slot_hit_s;
  assign acc_multi_s    = multi_q | (slot_hit_s & (hit_q | ~is_single_low(sync2_q)));
  assign frame_single_s = acc_hit_s & ~acc_multi_s;
  assign frame_code_s   = hit_q ? code_q : {row_q, sync2_q};

  // Slot timing, row rotation and per-frame hit accumulation.
  always_comb begin
    slot_d  = slot_q + SW'(1);
    row_d   = row_q;
    hit_d   = hit_q;
    multi_d = multi_q;
    code_d  = code_q;
    if (slot_last_s) begin
      slot_d = '0;
      row_d  = {row_q[2:0], row_q[3]};
      if (frame_end_s) begin
        hit_d   = 1'b0;
        multi_d = 1'b0;
        code_d  = 8'hFF;
      end else begin
        hit_d   = acc_hit_s;
        multi_d = acc_multi_s;
        if (slot_hit_s && !hit_q) begin
          code_d = {row_q, sync2_q};
        end else begin
          code_d = code_q;
        end
      end
    end else begin
      slot_d = slot_q + SW'(1);
    end
  end

  // Scan state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= '0;
      row_q   <= 4'b1110;
      hit_q   <= 1'b0;
      multi_q <= 1'b0;
      code_q  <= 8'hFF;
    end else begin
      slot_q  <= slot_d;
      row_q   <= row_d;
      hit_q   <= hit_d;
      multi_q <= multi_d;
      code_q  <= code_d;
    end
  end

  assign cnt_inc_s    = cnt_q + CW'(1);
  assign match_cand_s = frame_single_s && (frame_code_s == cand_q);
  assign match_key_s  = frame_single_s && (frame_code_s == coord_q);

  // Debounce state machine; it only moves on frame boundaries.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    coord_d    = coord_q;
    held_d     = held_q;
    valid_d    = 1'b0;
    released_d = 1'b0;
    if (frame_end_s) begin
      case (state_q)
        IDLE: begin
          if (frame_single_s) begin
            cand_d  = frame_code_s;
            cnt_d   = CW'(1);
            state_d = DEB_PRESS;
          end else begin
            state_d = IDLE;
          end
        end
        DEB_PRESS: begin
          if (match_cand_s) begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s == CNT_DONE) begin
              coord_d = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = HELD;
            end else begin
              state_d = DEB_PRESS;
            end
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (match_key_s) begin
            state_d = HELD;
          end else begin
            cnt_d   = CW'(1);
            state_d = DEB_RELEASE;
          end
        end
        DEB_RELEASE: begin
          if (match_key_s) begin
            cnt_d   = '0;
            state_d = HELD;
          end else begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s == CNT_DONE) begin
              held_d     = 1'b0;
              released_d = 1'b1;
              cnt_d      = '0;
              state_d    = IDLE;
            end else begin
              state_d = DEB_RELEASE;
            end
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cand_q     <= 8'hFF;
      coord_q    <= 8'hFF;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
      released_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      coord_q    <= coord_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
      released_q <= released_d;
    end
  end

  assign row_out      = row_q;
  assign key_coord    = coord_q;
  assign key_valid    = valid_q;
  assign key_held     = held_q;
  assign key_released = released_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix model.
module tb_keypad_scanner;

  localparam int FRAME = 32;
  localparam int K1    = 0;
  localparam int KA    = 3;
  localparam int K5    = 5;
  localparam int K7    = 8;
  localparam int K8    = 9;
  localparam int KHASH = 14;

  logic       clk;
  logic       rst;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [7:0] key_coord;
  logic       key_valid;
  logic       key_held;
  logic       key_released;

  logic [15:0] keys;
  logic [3:0]  rot_tab [4];

  int checks;
  int errors;
  int v_cnt;
  int r_cnt;
  int both_cnt;

  keypad_scanner #(
    .SCAN_DIV       (8),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .col_in      (col_in),
    .row_out     (row_out),
    .key_coord   (key_coord),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_released(key_released)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed key at (r, c) shorts row r to column c; keys index is r*4+c.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_out[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[r*4+c]) col_in[c] = 1'b0;
        end
      end
    end
  end

  task automatic run_cycles(input int n);
    v_cnt = 0;
    r_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (key_valid) v_cnt++;
      if (key_released) r_cnt++;
      if (key_valid && key_released) both_cnt++;
    end
  endtask

  task automatic run_frames(input int n);
    run_cycles(n * FRAME);
  endtask

  task automatic test_reset();
    int vc;
    rst  = 1'b1;
    keys = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL reset_row got %b exp 1110", row_out); end
    checks++; if (key_coord !== 8'hFF) begin errors++; $display("FAIL reset_coord got %h exp ff", key_coord); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b exp 0", key_held); end
    checks++; if (key_released !== 1'b0) begin errors++; $display("FAIL reset_released got %b exp 0", key_released); end
    rst = 1'b0;
    vc = 0;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      if (key_valid) vc++;
      checks++;
      if (row_out !== rot_tab[(i / 8) % 4]) begin
        errors++;
        $display("FAIL row_rotation cycle %0d got %b exp %b", i, row_out, rot_tab[(i / 8) % 4]);
      end
    end
    run_frames(9);
    checks++; if (vc + v_cnt != 0) begin errors++; $display("FAIL idle_no_valid got %0d exp 0", vc + v_cnt); end
  endtask

  task automatic test_clean_press();
    checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL press_align got %b exp 1110", row_out); end
    keys = 16'h0001 << K5;
    run_frames(2);
    checks++; if (v_cnt != 0) begin errors++; $display("FAIL press_early got %0d exp 0", v_cnt); end
    run_frames(1);
    checks++; if (v_cnt != 1) begin errors++; $display("FAIL press_pulse got %0d exp 1", v_cnt); end
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL press_valid_timing got %b exp 1", key_valid); end
    checks++; if (key_coord !== 8'hDD) begin errors++; $display("FAIL press_coord got %h exp dd", key_coord); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held got %b exp 1", key_held); end
    run_frames(10);
    checks++; if (v_cnt != 0) begin errors++; $display("FAIL press_repeat got %0d exp 0", v_cnt); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_still_held got %b exp 1", key_held); end
    keys = 16'h0000;
    run_frames(3);
    checks++; if (r_cnt != 1) begin errors++; $display("FAIL press_release got %0d exp 1", r_cnt); end
    checks++; if (key_released !== 1'b1) begin errors++; $display("FAIL press_release_timing got %b exp 1", key_released); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL press_held_clear got %b exp 0", key_held); end
  endtask

  task automatic test_bounce();
    int vc;
    checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL bounce_align got %b exp 1110", row_out); end
    keys = 16'h0001 << KA;
    run_frames(2);
    vc = v_cnt;
    keys = 16'h0000;
    run_frames(1);
    vc += v_cnt;
    keys = 16'h0001 << KA;
    run_frames(2);
    vc += v_cnt;
    checks++; if (vc != 0) begin errors++; $display("FAIL bounce_early got %0d exp 0", vc); end
    run_frames(1);
    checks++; if (v_cnt != 1) begin errors++; $display("FAIL bounce_pulse got %0d exp 1", v_cnt); end
    checks++; if (key_coord !== 8'hE7) begin errors++; $display("FAIL bounce_coord got %h exp e7", key_coord); end
    keys = 16'h0000;
    run_frames(3);
    checks++; if (r_cnt != 1) begin errors++; $display("FAIL bounce_release got %0d exp 1", r_cnt); end
  endtask

  task automatic test_multi();
    keys = (16'h0001 << K1) | (16'h0001 << K5);
    run_frames(10);
    checks++; if (v_cnt != 0) begin errors++; $display("FAIL multi_valid got %0d exp 0", v_cnt); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_held got %b exp 0", key_held); end
    checks++; if (key_coord !== 8'hE7) begin errors++; $display("FAIL multi_coord got %h exp e7", key_coord); end
    keys = 16'h0000;
    run_frames(1);
  endtask

  task automatic test_release();
    int rc;
    checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL release_align got %b exp 1110", row_out); end
    keys = 16'h0001 << KHASH;
    run_frames(3);
    checks++; if (v_cnt != 1) begin errors++; $display("FAIL release_press got %0d exp 1", v_cnt); end
    checks++; if (key_coord !== 8'h7B) begin errors++; $display("FAIL release_coord got %h exp 7b", key_coord); end
    keys = 16'h0000;
    run_frames(1);
    rc = r_cnt;
    keys = 16'h0001 << KHASH;
    run_frames(2);
    rc += r_cnt;
    checks++; if (rc != 0) begin errors++; $display("FAIL release_glitch got %0d exp 0", rc); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL release_glitch_held got %b exp 1", key_held); end
    keys = 16'h0000;
    run_frames(2);
    checks++; if (r_cnt != 0) begin errors++; $display("FAIL release_early got %0d exp 0", r_cnt); end
    run_frames(1);
    checks++; if (r_cnt != 1) begin errors++; $display("FAIL release_pulse got %0d exp 1", r_cnt); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_held got %b exp 0", key_held); end
    checks++; if (key_coord !== 8'h7B) begin errors++; $display("FAIL release_coord_kept got %h exp 7b", key_coord); end
  endtask

  task automatic test_key_change();
    int vc;
    checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL change_align got %b exp 1110", row_out); end
    keys = 16'h0001 << K7;
    run_frames(3);
    checks++; if (v_cnt != 1) begin errors++; $display("FAIL change_press7 got %0d exp 1", v_cnt); end
    checks++; if (key_coord !== 8'hBE) begin errors++; $display("FAIL change_coord7 got %h exp be", key_coord); end
    keys = 16'h0001 << K8;
    run_frames(2);
    checks++; if (r_cnt != 0) begin errors++; $display("FAIL change_early_release got %0d exp 0", r_cnt); end
    vc = v_cnt;
    run_frames(1);
    vc += v_cnt;
    checks++; if (r_cnt != 1) begin errors++; $display("FAIL change_release7 got %0d exp 1", r_cnt); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL change_held_clear got %b exp 0", key_held); end
    checks++; if (key_coord !== 8'hBE) begin errors++; $display("FAIL change_coord_kept got %h exp be", key_coord); end
    run_frames(2);
    vc += v_cnt;
    checks++; if (vc != 0) begin errors++; $display("FAIL change_rollover got %0d exp 0", vc); end
    run_frames(1);
    checks++; if (v_cnt != 1) begin errors++; $display("FAIL change_press8 got %0d exp 1", v_cnt); end
    checks++; if (key_coord !== 8'hBD) begin errors++; $display("FAIL change_coord8 got %h exp bd", key_coord); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL change_held8 got %b exp 1", key_held); end
    keys = 16'h0000;
    run_frames(3);
    checks++; if (r_cnt != 1) begin errors++; $display("FAIL change_release8 got %0d exp 1", r_cnt); end
  endtask

  task automatic test_reset_mid();
    int vc;
    checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL rstmid_align got %b exp 1110", row_out); end
    keys = 16'h0001 << K5;
    run_frames(1);
    vc = v_cnt;
    run_cycles(16);
    vc += v_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (vc != 0) begin errors++; $display("FAIL rstmid_partial got %0d exp 0", vc); end
    checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL rstmid_row got %b exp 1110", row_out); end
    checks++; if (key_coord !== 8'hFF) begin errors++; $display("FAIL rstmid_coord got %h exp ff", key_coord); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", key_valid); end
    run_frames(2);
    checks++; if (v_cnt != 0) begin errors++; $display("FAIL rstmid_early got %0d exp 0", v_cnt); end
    run_frames(1);
    checks++; if (v_cnt != 1) begin errors++; $display("FAIL rstmid_pulse got %0d exp 1", v_cnt); end
    checks++; if (key_coord !== 8'hDD) begin errors++; $display("FAIL rstmid_coord5 got %h exp dd", key_coord); end
    keys = 16'h0000;
    run_frames(3);
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL pulse_overlap got %0d exp 0", both_cnt); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    both_cnt = 0;
    rot_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst      = 1'b1;
    keys     = 16'h0000;
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_release();
    test_key_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
